tetris_board_ctrl: RTL and testbench

- Upstream stage of the playfield color mapper.
- Owns the 20x10 locked-cell array and the falling tetromino, and executes move, rotate and drop commands with collision checks.
- Locks pieces, clears full rows, and raises game over.
- Drives the composed grid[20][10] of 3-bit color codes that the mapper renders: 0 = empty, 1..7 = piece type I,O,T,S,Z,J,L.

---
 rtl/tetris_pkg.sv | 42 ++++
 rtl/tetromino_shape_rom.sv | 38 +++
 rtl/tetris_board_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_tetris_board_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and board geometry for the tetris playfield controller.
package tetris_pkg;

  localparam int ROWS      = 20;
  localparam int COLS      = 10;
  localparam int SPAWN_COL = 3;

  typedef logic [2:0] cell_t;
  typedef cell_t [COLS-1:0] row_t;
  typedef row_t  [ROWS-1:0] board_t;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PIECE_I = 3'd1,
    PIECE_O = 3'd2,
    PIECE_T = 3'd3,
    PIECE_S = 3'd4,
    PIECE_Z = 3'd5,
    PIECE_J = 3'd6,
    PIECE_L = 3'd7
  } piece_e;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROT_CW    = 3'd3,
    CMD_SOFT_DOWN = 3'd4,
    CMD_HARD_DROP = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_PLAY,
    ST_DROP,
    ST_LOCK,
    ST_SCAN,
    ST_OVER
  } state_e;

endpackage

// File: rtl/tetromino_shape_rom.sv
// Combinational shape table: (piece, rotation) -> four (dr,dc) cell offsets in a 4x4 box.
module tetromino_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]      piece,
  input  logic [1:0]      rot,
  output logic [3:0][1:0] dr,
  output logic [3:0][1:0] dc
);

  logic [15:0] code;

  // Each nibble is one cell as {dr,dc}; table index is piece*4 + rot.
  always_comb begin
    case ({piece, rot})
      5'd4:  code = 16'h4567;  5'd5:  code = 16'h26AE;
      5'd6:  code = 16'h89AB;  5'd7:  code = 16'h159D;
      5'd8:  code = 16'h1256;  5'd9:  code = 16'h1256;
      5'd10: code = 16'h1256;  5'd11: code = 16'h1256;
      5'd12: code = 16'h1456;  5'd13: code = 16'h1569;
      5'd14: code = 16'h4569;  5'd15: code = 16'h1459;
      5'd16: code = 16'h1245;  5'd17: code = 16'h156A;
      5'd18: code = 16'h5689;  5'd19: code = 16'h0459;
      5'd20: code = 16'h0156;  5'd21: code = 16'h2569;
      5'd22: code = 16'h459A;  5'd23: code = 16'h1458;
      5'd24: code = 16'h0456;  5'd25: code = 16'h1259;
      5'd26: code = 16'h456A;  5'd27: code = 16'h1589;
      5'd28: code = 16'h2456;  5'd29: code = 16'h159A;
      5'd30: code = 16'h4568;  5'd31: code = 16'h0159;
      default: code = 16'h0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      dr[i] = code[4*(3-i)+2 +: 2];
      dc[i] = code[4*(3-i)   +: 2];
    end
  end

endmodule

// File: rtl/tetris_board_ctrl.sv
// Playfield controller: falling piece, collision-checked moves, locking, row clears, game over.
module tetris_board_ctrl
  import tetris_pkg::*;
(
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             start,
  input  logic                             cmd_valid,
  input  logic [2:0]                       cmd,
  output logic                             cmd_ready,
  input  logic                             gravity_tick,
  input  logic [2:0]                       next_type,
  output logic                             next_req,
  output logic [ROWS-1:0][COLS-1:0][2:0]   grid,
  output logic                             clear_valid,
  output logic [2:0]                       clear_count,
  output logic [15:0]                      lines_total,
  output logic                             game_over
);

  localparam logic signed [6:0] ROW_MAX = 7'(ROWS - 1);
  localparam logic signed [5:0] COL_MAX = 6'(COLS - 1);

  state_e            state, state_nxt;
  board_t            locked;
  cell_t             ptype;
  logic [1:0]        rot;
  logic signed [5:0] org_row;
  logic signed [4:0] org_col;
  logic              pending;
  logic [4:0]        scan_r;
  logic [2:0]        acc;

  cell_t             cand_type;
  logic [1:0]        cand_rot;
  logic signed [5:0] cand_row;
  logic signed [4:0] cand_col;
  logic              has_cmd, move_down, hard, cand_hit, row_full;
  logic [3:0][1:0]   cur_dr, cur_dc, cand_dr, cand_dc;
  logic signed [6:0] ov_row [4];
  logic signed [5:0] ov_col [4];
  logic signed [6:0] ck_row [4];
  logic signed [5:0] ck_col [4];
  logic [16:0]       lines_sum;

  tetromino_shape_rom u_cur_rom  (.piece(ptype),     .rot(rot),      .dr(cur_dr),  .dc(cur_dc));
  tetromino_shape_rom u_cand_rom (.piece(cand_type), .rot(cand_rot), .dr(cand_dr), .dc(cand_dc));

  assign has_cmd = cmd_valid && (cmd inside {CMD_LEFT, CMD_RIGHT, CMD_ROT_CW,
                                             CMD_SOFT_DOWN, CMD_HARD_DROP});

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cand_type = ptype;
    cand_rot  = rot;
    cand_row  = org_row;
    cand_col  = org_col;
    move_down = 1'b0;
    hard      = 1'b0;
    case (state)
      ST_SPAWN: begin
        cand_type = next_type;
        cand_rot  = 2'd0;
        cand_row  = 6'sd0;
        cand_col  = 5'(SPAWN_COL);
      end
      ST_PLAY: begin
        if (has_cmd) begin
          case (cmd)
            CMD_LEFT:      cand_col = org_col - 5'sd1;
            CMD_RIGHT:     cand_col = org_col + 5'sd1;
            CMD_ROT_CW:    cand_rot = rot + 2'd1;
            CMD_SOFT_DOWN: begin cand_row = org_row + 6'sd1; move_down = 1'b1; end
            default:       hard = 1'b1;
          endcase
        end else if (gravity_tick || pending) begin
          cand_row  = org_row + 6'sd1;
          move_down = 1'b1;
        end
      end
      ST_DROP: begin
        cand_row  = org_row + 6'sd1;
        move_down = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cand_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ck_row[i] = 7'(cand_row) + 7'(cand_dr[i]);
      ck_col[i] = 6'(cand_col) + 6'(cand_dc[i]);
      ov_row[i] = 7'(org_row) + 7'(cur_dr[i]);
      ov_col[i] = 6'(org_col) + 6'(cur_dc[i]);
      if (ck_col[i] < 6'sd0 || ck_col[i] > COL_MAX || ck_row[i] > ROW_MAX)
        cand_hit = 1'b1;
      else if (ck_row[i] >= 7'sd0 && locked[ck_row[i][4:0]][ck_col[i][3:0]] != '0)
        cand_hit = 1'b1;
    end
  end

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (locked[scan_r][c] == '0) row_full = 1'b0;
  end

  assign lines_sum = {1'b0, lines_total} + 17'(acc);

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    next_req    = 1'b0;
    clear_valid = 1'b0;
    clear_count = 3'd0;
    game_over   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SPAWN;
      ST_SPAWN: begin
        next_req  = 1'b1;
        state_nxt = cand_hit ? ST_OVER : ST_PLAY;
      end
      ST_PLAY: begin
        cmd_ready = 1'b1;
        if (hard)                       state_nxt = ST_DROP;
        else if (move_down && cand_hit) state_nxt = ST_LOCK;
      end
      ST_DROP:  if (cand_hit) state_nxt = ST_LOCK;
      ST_LOCK:  state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!row_full && scan_r == 5'd0) begin
          clear_valid = 1'b1;
          clear_count = acc;
          state_nxt   = ST_SPAWN;
        end
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (start) state_nxt = ST_SPAWN;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the locked array is real game state, not scratch storage, so it is reset with everything else.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      locked      <= '0;
      ptype       <= '0;
      rot         <= 2'd0;
      org_row     <= 6'sd0;
      org_col     <= 5'sd0;
      pending     <= 1'b0;
      scan_r      <= 5'd0;
      acc         <= 3'd0;
      lines_total <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            locked      <= '0;
            lines_total <= 16'd0;
          end
        end
        ST_SPAWN: begin
          ptype   <= next_type;
          rot     <= 2'd0;
          org_row <= 6'sd0;
          org_col <= 5'(SPAWN_COL);
        end
        ST_PLAY: begin
          if (!cand_hit) begin
            rot     <= cand_rot;
            org_row <= cand_row;
            org_col <= cand_col;
          end
          // A tick colliding with a command waits one cycle; a further tick meanwhile is lost.
          if (has_cmd) begin
            if (gravity_tick) pending <= 1'b1;
          end else if (gravity_tick || pending) begin
            pending <= 1'b0;
          end
        end
        ST_DROP: if (!cand_hit) org_row <= cand_row;
        ST_LOCK: begin
          for (int i = 0; i < 4; i++)
            locked[ov_row[i][4:0]][ov_col[i][3:0]] <= ptype;
          pending <= 1'b0;
          scan_r  <= 5'(ROWS - 1);
          acc     <= 3'd0;
        end
        ST_SCAN: begin
          if (row_full) begin
            for (int r = 1; r < ROWS; r++)
              if (5'(r) <= scan_r) locked[r] <= locked[r-1];
            locked[0] <= '0;
            acc       <= acc + 3'd1;
          end else if (scan_r != 5'd0) begin
            scan_r <= scan_r - 5'd1;
          end else begin
            lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Composed view: active piece drawn over the locked cells only while it is falling.
  always_comb begin
    grid = locked;
    if (state == ST_PLAY || state == ST_DROP) begin
      for (int i = 0; i < 4; i++)
        if (ov_row[i] >= 7'sd0 && ov_row[i] <= ROW_MAX &&
            ov_col[i] >= 6'sd0 && ov_col[i] <= COL_MAX)
          grid[ov_row[i][4:0]][ov_col[i][3:0]] = ptype;
    end
  end

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Directed scenarios for tetris_board_ctrl with a clear-event scoreboard checked by a monitor.
module tb_tetris_board_ctrl;
  import tetris_pkg::*;

  logic        Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, cmd_valid = 1'b0, gravity_tick = 1'b0;
  logic [2:0]  cmd = 3'd0, next_type = 3'd0;
  logic        cmd_ready, next_req, clear_valid, game_over;
  logic [2:0]  clear_count;
  logic [15:0] lines_total;
  board_t      grid, exp_g;

  int pass_cnt = 0, total_cnt = 0, nreq_cnt = 0, exp_lines = 0, nreq_base = 0;

  typedef struct { logic [2:0] count; logic [15:0] total; } clr_t;
  clr_t clr_q[$];

  tetris_board_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .gravity_tick(gravity_tick), .next_type(next_type),
    .next_req(next_req), .grid(grid), .clear_valid(clear_valid), .clear_count(clear_count),
    .lines_total(lines_total), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (next_req) nreq_cnt++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic check_grid(string name);
    total_cnt++;
    if (grid === exp_g) pass_cnt++;
    else $display("FAIL %s: grid got %h required %h", name, grid, exp_g);
  endtask

  task automatic fail_now(string name, string what);
    total_cnt++;
    $display("FAIL %s: got %s", name, what);
  endtask

  task automatic put(int r, int c, logic [2:0] v);
    exp_g[r][c] = v;
  endtask

  task automatic push_clear(int n);
    exp_lines = (exp_lines + n > 65535) ? 65535 : exp_lines + n;
    clr_q.push_back('{count: 3'(n), total: 16'(exp_lines)});
  endtask

  task automatic cmd_cycle(logic [2:0] c, logic tick);
    cmd_valid = 1'b1; cmd = c; gravity_tick = tick;
    @(negedge Clk);
    cmd_valid = 1'b0; cmd = CMD_NONE; gravity_tick = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0; cmd_valid = 1'b0; gravity_tick = 1'b0; cmd = CMD_NONE;
    Reset_n = 1'b0;
    clr_q.delete();
    exp_lines = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic start_game(logic [2:0] t);
    next_type = t; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic hard_drop(int n_clear);
    push_clear(n_clear);
    cmd_cycle(CMD_HARD_DROP, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready || game_over) return;
      @(negedge Clk);
    end
    fail_now("hard_drop_settle", "no PLAY/OVER within 300 cycles, required settle");
  endtask

  // Scoreboard monitor: each clear_valid consumes one expected event.
  initial begin
    clr_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && clear_valid) begin
        if (clr_q.size() == 0) begin
          fail_now("clear_unexpected", "clear_valid with empty scoreboard, required none");
        end else begin
          e = clr_q.pop_front();
          check("clear_count", 32'(clear_count), 32'(e.count));
          @(negedge Clk);
          check("lines_total_after_clear", 32'(lines_total), 32'(e.total));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and O spawn
    do_reset();
    exp_g = '0;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_next_req", 32'(next_req), 0);
    check("rst_clear_valid", 32'(clear_valid), 0);
    check("rst_clear_count", 32'(clear_count), 0);
    check("rst_lines_total", 32'(lines_total), 0);
    check_grid("rst_grid");

    nreq_base = nreq_cnt;
    start_game(PIECE_O);
    check("spawn_next_req_once", 32'(nreq_cnt - nreq_base), 1);
    check("spawn_cmd_ready", 32'(cmd_ready), 1);
    exp_g = '0; put(0,4,2); put(0,5,2); put(1,4,2); put(1,5,2);
    check_grid("spawn_o_grid");

    start = 1'b1; @(negedge Clk); start = 1'b0;
    check_grid("start_in_play_ignored");
    check("start_in_play_no_req", 32'(nreq_cnt - nreq_base), 1);

    // Command beats the tick; the tick lands one cycle later
    cmd_cycle(CMD_LEFT, 1'b1);
    exp_g = '0; put(0,3,2); put(0,4,2); put(1,3,2); put(1,4,2);
    check_grid("left_with_tick");
    @(negedge Clk);
    exp_g = '0; put(1,3,2); put(1,4,2); put(2,3,2); put(2,4,2);
    check_grid("pending_tick_applied");
    @(negedge Clk);
    check_grid("pending_cleared");

    cmd_cycle(CMD_RIGHT, 1'b1);
    cmd_cycle(CMD_RIGHT, 1'b1);
    repeat (2) @(negedge Clk);
    exp_g = '0; put(2,5,2); put(2,6,2); put(3,5,2); put(3,6,2);
    check_grid("second_tick_dropped");

    next_type = PIECE_T;
    hard_drop(0);
    exp_g = '0; put(18,5,2); put(18,6,2); put(19,5,2); put(19,6,2);
    put(0,4,3); put(1,3,3); put(1,4,3); put(1,5,3);
    check_grid("o_locked_t_spawn");
    cmd_cycle(CMD_ROT_CW, 1'b0);
    exp_g = '0; put(18,5,2); put(18,6,2); put(19,5,2); put(19,6,2);
    put(0,4,3); put(1,4,3); put(1,5,3); put(2,4,3);
    check_grid("t_rotate");
    cmd_cycle(CMD_SOFT_DOWN, 1'b0);
    exp_g = '0; put(18,5,2); put(18,6,2); put(19,5,2); put(19,6,2);
    put(1,4,3); put(2,4,3); put(2,5,3); put(3,4,3);
    check_grid("t_soft_down");

    // Walls and a single-row clear
    do_reset();
    start_game(PIECE_I);
    repeat (5) cmd_cycle(CMD_LEFT, 1'b0);
    exp_g = '0;
    for (int c = 0; c < 4; c++) put(1, c, 1);
    check_grid("i_left_wall");
    next_type = PIECE_O;
    hard_drop(0);
    next_type = PIECE_I;
    hard_drop(0);
    repeat (4) cmd_cycle(CMD_RIGHT, 1'b0);
    exp_g = '0;
    for (int c = 0; c < 4; c++) put(19, c, 1);
    put(18,4,2); put(18,5,2); put(19,4,2); put(19,5,2);
    for (int c = 6; c < 10; c++) put(1, c, 1);
    check_grid("i_right_wall");
    next_type = PIECE_O;
    hard_drop(1);
    exp_g = '0; put(19,4,2); put(19,5,2);
    put(0,4,2); put(0,5,2); put(1,4,2); put(1,5,2);
    check_grid("after_single_clear");
    check("lines_total_one", 32'(lines_total), 1);

    // Reset in the middle of a row scan
    cmd_cycle(CMD_HARD_DROP, 1'b0);
    repeat (25) @(negedge Clk);
    do_reset();
    exp_g = '0;
    check_grid("mid_scan_reset_grid");
    check("mid_scan_reset_lines", 32'(lines_total), 0);
    check("mid_scan_reset_ready", 32'(cmd_ready), 0);

    // Four-row clear with vertical I pieces
    start_game(PIECE_I);
    for (int c = 0; c < 10; c++) begin
      cmd_cycle(CMD_ROT_CW, 1'b0);
      if (c < 5) repeat (5 - c) cmd_cycle(CMD_LEFT, 1'b0);
      else       repeat (c - 5) cmd_cycle(CMD_RIGHT, 1'b0);
      if (c == 9) begin
        exp_g = '0;
        for (int r = 16; r < 20; r++)
          for (int k = 0; k < 9; k++) put(r, k, 1);
        for (int r = 0; r < 4; r++) put(r, 9, 1);
        check_grid("pre_tetris");
      end
      hard_drop(c == 9 ? 4 : 0);
    end
    exp_g = '0;
    for (int c = 3; c < 7; c++) put(1, c, 1);
    check_grid("after_tetris");
    check("lines_total_four", 32'(lines_total), 4);

    // Stack O pieces until spawn collides
    do_reset();
    start_game(PIECE_O);
    for (int k = 0; k < 10; k++) hard_drop(0);
    check("over_game_over", 32'(game_over), 1);
    check("over_cmd_ready", 32'(cmd_ready), 0);
    exp_g = '0;
    for (int r = 0; r < 20; r++) begin put(r, 4, 2); put(r, 5, 2); end
    check_grid("over_grid");
    repeat (3) @(negedge Clk);
    check_grid("over_grid_frozen");
    start_game(PIECE_T);
    check("restart_game_over", 32'(game_over), 0);
    check("restart_cmd_ready", 32'(cmd_ready), 1);
    check("restart_lines", 32'(lines_total), 0);
    exp_g = '0; put(0,4,3); put(1,3,3); put(1,4,3); put(1,5,3);
    check_grid("restart_grid");

    check("scoreboard_drained", 32'(clr_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
